// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock, LSB first.
// Latency: DONE pulses WIDTH edges after the accepting START edge; results held afterwards.
// Backpressure: START is only accepted in IDLE/DONE; START during RUN is ignored (no queueing).
// Optional feature macro: SERIAL_SUB_OVF_EN enables signed-overflow detection; otherwise OVF is 0.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

`ifdef SERIAL_SUB_OVF_EN
    // Original operand sign bits, needed at the end because the shift registers lose them.
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    // Full-subtractor cell for the current bit step.
    logic a0;
    logic b0;
    logic d_bit;
    logic br_d;
    logic last_bit;

    assign a0       = a_q[0];
    assign b0       = b_q[0];
    assign d_bit    = a0 ^ b0 ^ br_q;
    assign br_d     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Accept: capture operands, clear previous results.
                        state_q  <= S_RUN;
                        a_q      <= a_i;
                        b_q      <= b_i;
                        diff_q   <= '0;
                        cnt_q    <= '0;
                        br_q     <= 1'b0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= a_i[WIDTH-1];
                        b_msb_q  <= b_i[WIDTH-1];
                        ovf_q    <= 1'b0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q  <= S_DONE;
                        borrow_q <= br_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // Overflow only when signs differ and the result sign departs from A.
                        ovf_q    <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o    = ovf_q;
`else
    assign ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random subtractions against
// an arithmetic reference model, START-ignored-in-RUN, mid-run reset and back-to-back.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
module tb_serial_subtractor;

    localparam int W     = 32;
    localparam int BOUND = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         busy;
    logic         done;

    int checks = 0;
    int fails  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .a_i      (a_in),
        .b_i      (b_in),
        .diff_o   (diff),
        .borrow_o (borrow),
        .ovf_o    (ovf),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    // Reference model: plain modular / signed arithmetic.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return a - b;
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_SUB_OVF_EN
        longint r;
        longint maxv;
        longint minv;
        r    = longint'($signed(a)) - longint'($signed(b));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        return (r > maxv) || (r < minv);
`else
        return 1'b0 & a[0] & b[0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one START cycle; returns 1ns after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    // Wait (bounded) for DONE; reports cycles elapsed and cycles BUSY was seen high.
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (!done && n < BOUND) begin
            if (busy) busy_n++;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 32'h1234_5678;
        b_in  = 32'h0000_0001;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checks++; if (diff !== '0)   begin fails++; $display("FAIL reset_diff: got %h want 0", diff); end
        checks++; if (borrow !== 0)  begin fails++; $display("FAIL reset_borrow: got %b want 0", borrow); end
        checks++; if (ovf !== 0)     begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 0)    begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tick();
        checks++; if (busy !== 0)    begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;
        int bn;
        ta = '{32'd5, 32'd3, 32'h8000_0000, 32'h7FFF_FFFF};
        tb = '{32'd3, 32'd5, 32'd1,         32'hFFFF_FFFF};
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                a = ta[i];
                b = tb[i];
            end else begin
                a = $urandom;
                b = $urandom;
                if (i % 3 == 0) b = a;
            end
            issue(a, b);
            wait_done(n, bn);
            checks++; if (n !== W)      begin fails++; $display("FAIL sub_latency[%0d]: got %0d want %0d", i, n, W); end
            checks++; if (bn !== W)     begin fails++; $display("FAIL sub_busy_cycles[%0d]: got %0d want %0d", i, bn, W); end
            checks++; if (busy !== 0)   begin fails++; $display("FAIL sub_busy_at_done[%0d]: got %b want 0", i, busy); end
            checks++; if (diff !== ref_diff(a, b))
                begin fails++; $display("FAIL sub_diff[%0d] a=%h b=%h: got %h want %h", i, a, b, diff, ref_diff(a, b)); end
            checks++; if (borrow !== ref_borrow(a, b))
                begin fails++; $display("FAIL sub_borrow[%0d] a=%h b=%h: got %b want %b", i, a, b, borrow, ref_borrow(a, b)); end
            checks++; if (ovf !== ref_ovf(a, b))
                begin fails++; $display("FAIL sub_ovf[%0d] a=%h b=%h: got %b want %b", i, a, b, ovf, ref_ovf(a, b)); end
            tick();
            checks++; if (done !== 0)   begin fails++; $display("FAIL sub_done_pulse[%0d]: got %b want 0", i, done); end
            checks++; if (diff !== ref_diff(a, b))
                begin fails++; $display("FAIL sub_diff_held[%0d]: got %h want %h", i, diff, ref_diff(a, b)); end
            checks++; if (borrow !== ref_borrow(a, b))
                begin fails++; $display("FAIL sub_borrow_held[%0d]: got %b want %b", i, borrow, ref_borrow(a, b)); end
        end
    endtask

    task automatic test_start_ignored();
        int n;
        int bn;
        int pulses;
        issue(32'd7, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        start = 1'b1;
        a_in  = 32'd0;
        b_in  = 32'd1;
        tick();
        start = 1'b0;
        wait_done(n, bn);
        checks++; if (n + 11 !== W) begin fails++; $display("FAIL ign_latency: got %0d want %0d", n + 11, W); end
        checks++; if (diff !== 32'd0) begin fails++; $display("FAIL ign_diff: got %h want 0", diff); end
        checks++; if (borrow !== 0)   begin fails++; $display("FAIL ign_borrow: got %b want 0", borrow); end
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL ign_extra_activity: got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int bn;
        int act;
        issue(32'hFFFF_FFFF, 32'd0);
        for (int i = 0; i < 16; i++) tick();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 32'd3;
        b_in  = 32'd1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checks++; if (diff !== '0)  begin fails++; $display("FAIL rmid_diff: got %h want 0", diff); end
        checks++; if (borrow !== 0) begin fails++; $display("FAIL rmid_borrow: got %b want 0", borrow); end
        checks++; if (ovf !== 0)    begin fails++; $display("FAIL rmid_ovf: got %b want 0", ovf); end
        checks++; if (busy !== 0)   begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (done !== 0)   begin fails++; $display("FAIL rmid_done: got %b want 0", done); end
        act = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done || busy) act++;
        end
        checks++; if (act !== 0) begin fails++; $display("FAIL rmid_no_done: got %0d active cycles want 0", act); end
        issue(32'd1, 32'd2);
        wait_done(n, bn);
        checks++; if (n !== W)               begin fails++; $display("FAIL rmid_latency: got %0d want %0d", n, W); end
        checks++; if (diff !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rmid_diff2: got %h want ffffffff", diff); end
        checks++; if (borrow !== 1)          begin fails++; $display("FAIL rmid_borrow2: got %b want 1", borrow); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        int n;
        int bn;
        pa = 32'd9;
        pb = 32'd4;
        issue(pa, pb);
        wait_done(n, bn);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 32'd4;
                b = 32'd9;
            end else begin
                a = $urandom;
                b = $urandom;
            end
            checks++; if (done !== 1) begin fails++; $display("FAIL b2b_done[%0d]: got %b want 1", i, done); end
            checks++; if (diff !== ref_diff(pa, pb))
                begin fails++; $display("FAIL b2b_prev_diff[%0d]: got %h want %h", i, diff, ref_diff(pa, pb)); end
            // Accept the next operation on the DONE edge.
            start = 1'b1;
            a_in  = a;
            b_in  = b;
            tick();
            start = 1'b0;
            a_in  = $urandom;
            b_in  = $urandom;
            checks++; if (busy !== 1)  begin fails++; $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy); end
            checks++; if (done !== 0)  begin fails++; $display("FAIL b2b_done_low[%0d]: got %b want 0", i, done); end
            checks++; if (diff !== '0) begin fails++; $display("FAIL b2b_diff_clr[%0d]: got %h want 0", i, diff); end
            wait_done(n, bn);
            checks++; if (n !== W) begin fails++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, n, W); end
            checks++; if (diff !== ref_diff(a, b))
                begin fails++; $display("FAIL b2b_diff[%0d]: got %h want %h", i, diff, ref_diff(a, b)); end
            checks++; if (borrow !== ref_borrow(a, b))
                begin fails++; $display("FAIL b2b_borrow[%0d]: got %b want %b", i, borrow, ref_borrow(a, b)); end
            checks++; if (ovf !== ref_ovf(a, b))
                begin fails++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i, ovf, ref_ovf(a, b)); end
            pa = a;
            pb = b;
        end
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        test_reset();
        test_subtract();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
